// File: rtl/word_shift_pkg.sv
// Shared definitions for the word-shift encoder/decoder pair: default geometry,
// flush FSM state encoding, and width-generic rotate helpers (words up to 64 bits).
package word_shift_pkg;

    localparam int W_DEF     = 8;
    localparam int ROT_A_DEF = 5;
    localparam int ROT_B_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic [63:0] width_mask(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    // n==0 returns early so the complementary shift never spans the full word
    function automatic logic [63:0] rotl(input logic [63:0] x, input int n, input int w);
        logic [63:0] xm;
        xm = x & width_mask(w);
        if (n == 0) return xm;
        return ((xm << n) | (xm >> (w - n))) & width_mask(w);
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        logic [63:0] xm;
        xm = x & width_mask(w);
        if (n == 0) return xm;
        return ((xm >> n) | (xm << (w - n))) & width_mask(w);
    endfunction

endpackage

// File: rtl/word_unshift_dec_rotr_stage.sv
// One valid/ready register stage that right-rotates the word by ROT as it is captured.
// The stage loads whenever its output slot is empty or being consumed this cycle.
module rotr_stage
    import word_shift_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int ROT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_vld,
    input  logic [W-1:0] up_data,
    output logic         up_rdy,
    output logic         dn_vld,
    output logic [W-1:0] dn_data,
    input  logic         dn_rdy
);

    assign up_rdy = !dn_vld | dn_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dn_vld  <= 1'b0;
            dn_data <= '0;
        end else if (up_rdy) begin
            dn_vld  <= up_vld;
            dn_data <= W'(rotr(64'(up_data), ROT, W));
        end
    end

endmodule

// File: rtl/word_unshift_dec.sv
// Word-shift decoder: rotr ROT_B then rotr ROT_A over two valid/ready stages, with flush/drain.
// Optional delivered-word counter on port word_cnt when WORD_UNSHIFT_CNT_EN is defined.
module word_unshift_dec
    import word_shift_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int ROT_A = ROT_A_DEF,
    parameter int ROT_B = ROT_B_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    input  logic         flush,
    output logic         flush_done
`ifdef WORD_UNSHIFT_CNT_EN
    ,
    output logic [15:0]  word_cnt
`endif
);

    state_t       state;
    state_t       state_nxt;
    logic         vld_p1;
    logic [W-1:0] data_p1;
    logic         s1_adv;
    logic         s2_adv;
    logic         in_xfer;
    logic         pipe_empty;
    logic         drain_done;
    logic         flush_hold;

    assign in_xfer    = in_valid & in_ready;
    assign pipe_empty = !vld_p1 & !out_valid;
    // flush_hold keeps input blocked after a completed drain until flush is released
    assign in_ready   = s1_adv & (state != DRAIN) & !(flush_hold & flush);

    // stage 1: undo the encoder's second rotate
    rotr_stage #(.W(W), .ROT(ROT_B)) u_stage1 (
        .clk     (clk),
        .rst     (rst),
        .up_vld  (in_xfer),
        .up_data (in_data),
        .up_rdy  (s1_adv),
        .dn_vld  (vld_p1),
        .dn_data (data_p1),
        .dn_rdy  (s2_adv)
    );

    // stage 2: undo the encoder's first rotate, drives the registered outputs
    rotr_stage #(.W(W), .ROT(ROT_A)) u_stage2 (
        .clk     (clk),
        .rst     (rst),
        .up_vld  (vld_p1),
        .up_data (data_p1),
        .up_rdy  (s2_adv),
        .dn_vld  (out_valid),
        .dn_data (out_data),
        .dn_rdy  (out_ready)
    );

    always_comb begin
        state_nxt  = state;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                if (flush && !flush_hold) state_nxt = DRAIN;
                else if (in_xfer)         state_nxt = RUN;
            end
            RUN: begin
                if (flush)                       state_nxt = DRAIN;
                else if (pipe_empty && !in_xfer) state_nxt = IDLE;
            end
            DRAIN: begin
                if (pipe_empty) begin
                    drain_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            flush_done <= 1'b0;
            flush_hold <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_done <= drain_done;
            flush_hold <= flush & (flush_hold | drain_done);
        end
    end

`ifdef WORD_UNSHIFT_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        word_cnt <= 16'h0000;
        else if (out_valid && out_ready) word_cnt <= word_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_word_unshift_dec.sv
// Bench for word_unshift_dec: scoreboard of net-rotation expectations plus directed scenarios.
// Counter checks are compiled in when WORD_UNSHIFT_CNT_EN is defined.
module tb_word_unshift_dec;
    import word_shift_pkg::*;

    localparam int RA = 5;
    localparam int RB = 3;

    logic       clk;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, flush, flush_done;
    logic [7:0] in_data, out_data;
    logic       in_valid2, in_ready2, out_valid2, out_ready2, flush2, flush_done2;
    logic [7:0] in_data2, out_data2;
`ifdef WORD_UNSHIFT_CNT_EN
    logic [15:0] word_cnt, word_cnt2;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    logic [7:0] sb_q[$];
    logic       held_v = 1'b0;
    logic [7:0] held_d = 8'h00;

    word_unshift_dec #(.W(8), .ROT_A(RA), .ROT_B(RB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .flush_done(flush_done)
`ifdef WORD_UNSHIFT_CNT_EN
        , .word_cnt(word_cnt)
`endif
    );

    word_unshift_dec #(.W(8), .ROT_A(1), .ROT_B(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .flush(flush2), .flush_done(flush_done2)
`ifdef WORD_UNSHIFT_CNT_EN
        , .word_cnt(word_cnt2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Decoded word = encoded word rotated right by the total of both amounts, bit by bit
    function automatic logic [7:0] model_dec(input logic [7:0] x, input int ra, input int rb);
        logic [7:0] r;
        r = x;
        for (int k = 0; k < (ra + rb) % 8; k++) r = {r[0], r[7:1]};
        return r;
    endfunction

    // Scoreboard compare on every cycle
    always @(negedge clk) begin
        if (!rst) begin
            sb_q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", {24'd0, out_data}, {24'd0, held_d});
            end
            if (in_valid && in_ready) sb_q.push_back(model_dec(in_data, RA, RB));
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) check("sb_underflow", {31'd0, out_valid}, 32'd0);
                else check("sb_data", {24'd0, out_data}, {24'd0, sb_q.pop_front()});
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent, cyc, base, pulses, last_xfer, done_c;
        logic acc;
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; flush = 1'b0;
        in_valid2 = 1'b0; in_data2 = 8'h00; out_ready2 = 1'b1; flush2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_flush_done", {31'd0, flush_done}, 32'd0);
`ifdef WORD_UNSHIFT_CNT_EN
        check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
`endif
        tick();
        rst = 1'b1;
        tick();

        // 1: default amounts sum to 8 -> identity, two-cycle latency
        in_valid = 1'b1; in_data = 8'h81;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_lat1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("t1_lat2_valid", {31'd0, out_valid}, 32'd1);
        check("t1_data", {24'd0, out_data}, 32'h81);
        tick();

        // 2: ROT_A=1, ROT_B=2 -> net rotr 3
        in_valid2 = 1'b1; in_data2 = 8'h81;
        tick();
        in_data2 = 8'h01;
        tick();
        in_valid2 = 1'b0;
        @(negedge clk);
        check("t2_valid_a", {31'd0, out_valid2}, 32'd1);
        check("t2_data_a", {24'd0, out_data2}, 32'h30);
        @(negedge clk);
        check("t2_data_b", {24'd0, out_data2}, 32'h20);
        tick();

        // 3: stream 0x00..0x0F with random backpressure
        base = n_out; sent = 0; cyc = 0;
        while (sent < 16 && cyc < 200) begin
            in_valid = 1'b1; in_data = 8'(sent); out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
        while (n_out - base < 16 && cyc < 50) begin tick(); cyc++; end
        check("t3_sent", sent, 16);
        check("t3_delivered", n_out - base, 16);
        check("t3_sb_empty", sb_q.size(), 0);

        // 4: stalled consumer admits only two words
        out_ready = 1'b0; sent = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'hA0 + 8'(sent);
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) sent++;
        end
        check("t4_accepted", sent, 2);
        @(negedge clk);
        check("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        out_ready = 1'b1; cyc = 0;
        while (sent < 3 && cyc < 10) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        repeat (4) tick();
        check("t4_sb_empty", sb_q.size(), 0);

        // 5: flush with two words in flight
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = 8'h50 + 8'(k);
            tick();
        end
        in_valid = 1'b0; flush = 1'b1;
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_in_ready_drain", {31'd0, in_ready}, 32'd0);
        pulses = 0; last_xfer = -1; done_c = -1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (out_valid && out_ready) last_xfer = c;
            if (flush_done) begin pulses++; done_c = c; end
        end
        check("t5_pulses", pulses, 1);
        check("t5_done_after_xfer", {31'd0, (done_c - last_xfer >= 1) && (done_c - last_xfer <= 2)}, 32'd1);
        check("t5_state_idle", {30'd0, dut.state}, {30'd0, IDLE});
        check("t5_in_ready_held", {31'd0, in_ready}, 32'd0);
        check("t5_sb_empty", sb_q.size(), 0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t5_in_ready_release", {31'd0, in_ready}, 32'd1);
        tick();

        // 6: asynchronous reset mid-stream
        in_valid = 1'b1; in_data = 8'h55;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("t6_out_valid", {31'd0, out_valid}, 32'd0);
        check("t6_out_data", {24'd0, out_data}, 32'd0);
        check("t6_flush_done", {31'd0, flush_done}, 32'd0);
`ifdef WORD_UNSHIFT_CNT_EN
        check("t6_word_cnt", {16'd0, word_cnt}, 32'd0);
`endif
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("t6_no_done", {31'd0, flush_done}, 32'd0);
`ifdef WORD_UNSHIFT_CNT_EN
        for (int k = 0; k < 65535; k++) begin
            in_valid = 1'b1; in_data = 8'(k);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        check("t6_cnt_ffff", {16'd0, word_cnt}, 32'h0000FFFF);
        in_valid = 1'b1; in_data = 8'h3C;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("t6_cnt_wrap", {16'd0, word_cnt}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
